// File: rtl/mdio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdio_pkg: shared MDIO frame encodings for mdio_phy_recep                 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ST2   = 3'd1,
    S_OP    = 3'd2,
    S_PHYAD = 3'd3,
    S_REGAD = 3'd4,
    S_TA    = 3'd5,
    S_DATA  = 3'd6
  } state_t;

  localparam int DATA_W = 16;

  localparam logic [1:0] ST_C22 = 2'b01;
  localparam logic [1:0] ST_C45 = 2'b00;

  localparam logic [1:0] OP_C22_WR     = 2'b01;
  localparam logic [1:0] OP_C22_RD     = 2'b10;
  localparam logic [1:0] OP_C45_ADDR   = 2'b00;
  localparam logic [1:0] OP_C45_WR     = 2'b01;
  localparam logic [1:0] OP_C45_RD_INC = 2'b10;
  localparam logic [1:0] OP_C45_RD     = 2'b11;

  localparam logic [1:0] TA_WR = 2'b10;

  // Both C45 read opcodes have op[1] set; C22 has a single read opcode.
  function automatic logic op_is_read(input logic c45, input logic [1:0] op);
    return c45 ? op[1] : (op == OP_C22_RD);
  endfunction

  function automatic logic op_valid_c22(input logic [1:0] op);
    return (op == OP_C22_WR) || (op == OP_C22_RD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_shift_out.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdio_shift_out: parallel-load, MSB-first serializer; load forces out = 0 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mdio_shift_out
  import mdio_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              dout
);

  logic [DATA_W-1:0] r_sr;
  logic              r_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr   <= '0;
      r_dout <= 1'b0;
    end else if (load) begin
      r_sr   <= din;
      r_dout <= 1'b0;
    end else if (shift) begin
      r_dout <= r_sr[DATA_W-1];
      r_sr   <= {r_sr[DATA_W-2:0], 1'b0};
    end
  end

  assign dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/mdio_phy_recep.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdio_phy_recep: PHY-side MDIO frame receiver (C22; C45 with MDIO_C45_EN) |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mdio_phy_recep
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd0,
  parameter int         PRE_LEN  = 32
) (
  input  logic        MDC,
  input  logic        rst,
  input  logic        MDIO_OE,
  input  logic        MDIO_OUT,
  input  logic [15:0] RD_DATA,
  output logic        MDIO_IN,
  output logic        MDIO_IN_OE,
  output logic        RD_STB,
  output logic        WR_STB,
  output logic        MDIO_DONE,
  output logic        ERR,
  output logic [15:0] ADDR,
  output logic [4:0]  DEV_ADDR,
  output logic [15:0] WR_DATA
);

  localparam logic [5:0] C_PRE_LEN = 6'(PRE_LEN);

  state_t      r_state, w_state_n;
  logic [3:0]  r_cnt, w_cnt_n;
  logic [5:0]  r_pre, w_pre_n;
  logic [14:0] r_sh;
  logic [1:0]  r_op, w_op_n;
  logic        r_c45, w_c45_n;
  logic        r_match, w_match_n;

  logic        r_rd_stb, r_wr_stb, r_done, r_err, r_oe;
  logic [15:0] r_addr, r_wr_data;
  logic [4:0]  r_dev;

  logic [15:0] w_sh_next;
  logic [4:0]  w_field;
  logic        w_read;
  logic        w_err, w_rd, w_wr, w_done, w_load, w_shift, w_oe_on, w_release;
  logic        w_set_regad, w_set_dev, w_load_addr, w_inc;

  assign w_sh_next = {r_sh, MDIO_OUT};
  assign w_field   = w_sh_next[4:0];
  assign w_read    = op_is_read(r_c45, r_op);

  always_ff @(posedge MDC or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pre   <= '0;
      r_sh    <= '0;
      r_op    <= '0;
      r_c45   <= 1'b0;
      r_match <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_pre   <= w_pre_n;
      r_sh    <= w_sh_next[14:0];
      r_op    <= w_op_n;
      r_c45   <= w_c45_n;
      r_match <= w_match_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt + 4'd1;
    w_pre_n     = r_pre;
    w_op_n      = r_op;
    w_c45_n     = r_c45;
    w_match_n   = r_match;
    w_err       = 1'b0;
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    w_done      = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_oe_on     = 1'b0;
    w_release   = 1'b0;
    w_set_regad = 1'b0;
    w_set_dev   = 1'b0;
    w_load_addr = 1'b0;
    w_inc       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        if (!MDIO_OE) begin
          w_pre_n = '0;
        end else if (MDIO_OUT) begin
          if (r_pre != C_PRE_LEN) w_pre_n = r_pre + 6'd1;
        end else begin
          w_pre_n = '0;
          if (r_pre == C_PRE_LEN) w_state_n = S_ST2;
        end
      end
      S_ST2: begin
        w_cnt_n = '0;
        if (!MDIO_OE) begin
          w_err = 1'b1;
        end else if (MDIO_OUT == ST_C22[0]) begin
          w_c45_n   = 1'b0;
          w_state_n = S_OP;
        end else begin
`ifdef MDIO_C45_EN
          w_c45_n   = 1'b1;
          w_state_n = S_OP;
`else
          w_err = 1'b1;
`endif
        end
      end
      S_OP: begin
        if (!MDIO_OE) begin
          w_err = 1'b1;
        end else if (r_cnt == 4'd1) begin
          w_op_n  = w_sh_next[1:0];
          w_cnt_n = '0;
          if (!r_c45 && !op_valid_c22(w_sh_next[1:0])) w_err = 1'b1;
          else w_state_n = S_PHYAD;
        end
      end
      S_PHYAD: begin
        if (!MDIO_OE) begin
          w_err = 1'b1;
        end else if (r_cnt == 4'd4) begin
          w_match_n = (w_field == PHY_ADDR);
          w_cnt_n   = '0;
          w_state_n = S_REGAD;
        end
      end
      S_REGAD: begin
        // Foreign frames are only counted through, never flagged.
        if (r_match && !MDIO_OE) begin
          w_err = 1'b1;
        end else if (r_cnt == 4'd4) begin
          w_cnt_n   = '0;
          w_state_n = S_TA;
          if (r_match) begin
            w_set_dev   = r_c45;
            w_set_regad = !r_c45;
            w_rd        = w_read;
          end
        end
      end
      S_TA: begin
        if (r_match && w_read) begin
          if (r_cnt == 4'd0) begin
            w_load  = 1'b1;
            w_oe_on = 1'b1;
          end else if (MDIO_OE) begin
            w_err = 1'b1;
          end else begin
            w_shift   = 1'b1;
            w_cnt_n   = '0;
            w_state_n = S_DATA;
          end
        end else if (r_match && (!MDIO_OE ||
                     (MDIO_OUT != (r_cnt[0] ? TA_WR[0] : TA_WR[1])))) begin
          w_err = 1'b1;
        end else if (r_cnt != 4'd0) begin
          w_cnt_n   = '0;
          w_state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (r_match && w_read) begin
          if (MDIO_OE) begin
            w_err = 1'b1;
          end else if (r_cnt == 4'd15) begin
            w_done    = 1'b1;
            w_release = 1'b1;
            w_inc     = r_c45 && (r_op == OP_C45_RD_INC);
            w_state_n = S_IDLE;
          end else begin
            w_shift = 1'b1;
          end
        end else if (r_match && !MDIO_OE) begin
          w_err = 1'b1;
        end else if (r_cnt == 4'd15) begin
          w_state_n = S_IDLE;
          if (r_match) begin
            w_done      = 1'b1;
            w_load_addr = r_c45 && (r_op == OP_C45_ADDR);
            w_wr        = !(r_c45 && (r_op == OP_C45_ADDR));
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    if (w_err) begin
      w_state_n = S_IDLE;
      w_cnt_n   = '0;
      w_pre_n   = '0;
      w_release = 1'b1;
    end
  end

  always_ff @(posedge MDC or negedge rst) begin
    if (!rst) begin
      r_rd_stb  <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_oe      <= 1'b0;
      r_addr    <= '0;
      r_dev     <= '0;
      r_wr_data <= '0;
    end else begin
      r_rd_stb <= w_rd && !w_err;
      r_wr_stb <= w_wr && !w_err;
      r_done   <= w_done && !w_err;
      r_err    <= w_err;
      if (w_release)    r_oe <= 1'b0;
      else if (w_oe_on) r_oe <= 1'b1;
      if (w_set_regad)      r_addr <= {11'b0, w_field};
      else if (w_load_addr) r_addr <= w_sh_next;
      else if (w_inc)       r_addr <= r_addr + 16'd1;
      if (w_set_regad)    r_dev <= '0;
      else if (w_set_dev) r_dev <= w_field;
      if (w_wr) r_wr_data <= w_sh_next;
    end
  end

  // A release also reloads zero so the line idles low once dropped.
  mdio_shift_out u_shift_out (
    .clk   (MDC),
    .rst_n (rst),
    .load  (w_load | w_release),
    .shift (w_shift),
    .din   (w_load ? RD_DATA : 16'h0000),
    .dout  (MDIO_IN)
  );

  assign MDIO_IN_OE = r_oe;
  assign RD_STB     = r_rd_stb;
  assign WR_STB     = r_wr_stb;
  assign MDIO_DONE  = r_done;
  assign ERR        = r_err;
  assign ADDR       = r_addr;
  assign DEV_ADDR   = r_dev;
  assign WR_DATA    = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_mdio_phy_recep.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mdio_phy_recep: table-driven frame bench for mdio_phy_recep           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mdio_phy_recep;

  localparam logic [4:0] PHY = 5'd5;

  logic        MDC = 1'b0;
  logic        rst;
  logic        MDIO_OE;
  logic        MDIO_OUT;
  logic [15:0] RD_DATA;
  logic        MDIO_IN, MDIO_IN_OE, RD_STB, WR_STB, MDIO_DONE, ERR;
  logic [15:0] ADDR, WR_DATA;
  logic [4:0]  DEV_ADDR;

  mdio_phy_recep #(.PHY_ADDR(PHY), .PRE_LEN(32)) dut (
    .MDC        (MDC),
    .rst        (rst),
    .MDIO_OE    (MDIO_OE),
    .MDIO_OUT   (MDIO_OUT),
    .RD_DATA    (RD_DATA),
    .MDIO_IN    (MDIO_IN),
    .MDIO_IN_OE (MDIO_IN_OE),
    .RD_STB     (RD_STB),
    .WR_STB     (WR_STB),
    .MDIO_DONE  (MDIO_DONE),
    .ERR        (ERR),
    .ADDR       (ADDR),
    .DEV_ADDR   (DEV_ADDR),
    .WR_DATA    (WR_DATA)
  );

  initial forever #5 MDC = ~MDC;

  typedef struct {
    int          pre;
    logic [1:0]  st;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [1:0]  ta;
    logic [15:0] data;
    logic        is_rd;
    int          cont_k;
    int          rst_k;
    logic [15:0] rd_data;
    int          e_wr;
    int          e_rd;
    int          e_done;
    int          e_err;
    int          e_oe;
    logic [15:0] e_wr_data;
    logic [15:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  int          n_wr, n_rd, n_done, n_err, n_oe, rd_k, done_k;
  logic [15:0] got_wr_data, got_wr_addr, got_rd_addr, got_done_addr;
  logic [16:0] rx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " ctl"}, 32'({MDIO_IN, MDIO_IN_OE, RD_STB, WR_STB, MDIO_DONE, ERR}), 32'd0);
    check({tag, " addr"}, 32'({DEV_ADDR, ADDR}), 32'd0);
    check({tag, " wdata"}, 32'(WR_DATA), 32'd0);
  endtask

  // Drive one bit on the falling edge, observe outputs just after the rising edge.
  task automatic drive_bit(input logic oe, input logic b, input int k);
    @(negedge MDC);
    MDIO_OE  = oe;
    MDIO_OUT = b;
    @(posedge MDC);
    #1;
    if (WR_STB) begin n_wr++; got_wr_data = WR_DATA; got_wr_addr = ADDR; end
    if (RD_STB) begin n_rd++; rd_k = k; got_rd_addr = ADDR; end
    if (MDIO_DONE) begin n_done++; done_k = k; got_done_addr = ADDR; end
    if (ERR) n_err++;
    if (MDIO_IN_OE) begin n_oe++; rx = {rx[15:0], MDIO_IN}; end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] w;
    string       t;
    t = $sformatf("v%0d", idx);
    w = {v.st, v.op, v.phy, v.regad, v.ta, v.data};
    n_wr = 0; n_rd = 0; n_done = 0; n_err = 0; n_oe = 0;
    rd_k = -1; done_k = -1; rx = '0;
    RD_DATA = v.rd_data;
    drive_bit(1'b1, 1'b0, -1);
    drive_bit(1'b1, 1'b0, -1);
    for (int i = 0; i < v.pre; i++) drive_bit(1'b1, 1'b1, -1);
    for (int k = 0; k < 32; k++) begin
      if (v.is_rd && k >= 14) drive_bit(k == v.cont_k, 1'b1, k);
      else                    drive_bit(1'b1, w[31-k], k);
      if (k == v.rst_k) begin
        #2 rst = 1'b0;
        #1 check_reset_state({t, " midrst"});
        rst = 1'b1;
      end
    end
    drive_bit(1'b1, 1'b0, 32);
    check({t, " wr_cnt"}, n_wr, v.e_wr);
    check({t, " rd_cnt"}, n_rd, v.e_rd);
    check({t, " done_cnt"}, n_done, v.e_done);
    check({t, " err_cnt"}, n_err, v.e_err);
    check({t, " oe_cycles"}, n_oe, v.e_oe);
    if (v.e_wr != 0) begin
      check({t, " wr_data"}, 32'(got_wr_data), 32'(v.e_wr_data));
      check({t, " wr_addr"}, 32'(got_wr_addr), 32'(v.e_addr));
    end
    if (v.e_rd != 0) begin
      check({t, " rd_stb_pos"}, rd_k, 13);
      check({t, " rd_addr"}, 32'(got_rd_addr), 32'(v.e_addr));
    end
    if (v.e_wr == 0 && v.e_rd == 0 && v.e_done != 0)
      check({t, " done_addr"}, 32'(got_done_addr), 32'(v.e_addr));
    if (v.e_done != 0) check({t, " done_pos"}, done_k, 31);
    if (v.e_rd != 0 && v.e_done != 0)
      check({t, " serial"}, 32'(rx), 32'({1'b0, v.rd_data}));
  endtask

  initial begin
    rst      = 1'b0;
    MDIO_OE  = 1'b0;
    MDIO_OUT = 1'b0;
    RD_DATA  = 16'h0000;
    @(posedge MDC);
    #1 check_reset_state("reset");
    @(negedge MDC);
    rst = 1'b1;

    //                  pre st     op     phy      reg     ta     data      rd    ck  rk  rd_data   wr rd dn er oe  wr_data   addr
    vecs.push_back(vec_t'{32, 2'b01, 2'b01, PHY,      5'h0A, 2'b10, 16'hBEEF, 1'b0, -1, -1, 16'h0000, 1, 0, 1, 0, 0,  16'hBEEF, 16'h000A});
    vecs.push_back(vec_t'{32, 2'b01, 2'b10, PHY,      5'h03, 2'b00, 16'h0000, 1'b1, -1, -1, 16'h1234, 0, 1, 1, 0, 17, 16'h0000, 16'h0003});
    vecs.push_back(vec_t'{32, 2'b01, 2'b01, PHY+5'd1, 5'h0A, 2'b10, 16'hBEEF, 1'b0, -1, -1, 16'h0000, 0, 0, 0, 0, 0,  16'h0000, 16'h0000});
    vecs.push_back(vec_t'{32, 2'b01, 2'b01, PHY,      5'h1F, 2'b10, 16'h8001, 1'b0, -1, -1, 16'h0000, 1, 0, 1, 0, 0,  16'h8001, 16'h001F});
    vecs.push_back(vec_t'{32, 2'b01, 2'b01, PHY,      5'h0A, 2'b11, 16'hBEEF, 1'b0, -1, -1, 16'h0000, 0, 0, 0, 1, 0,  16'h0000, 16'h0000});
    vecs.push_back(vec_t'{31, 2'b01, 2'b01, PHY,      5'h0A, 2'b10, 16'hBEEF, 1'b0, -1, -1, 16'h0000, 0, 0, 0, 0, 0,  16'h0000, 16'h0000});
    vecs.push_back(vec_t'{32, 2'b01, 2'b10, PHY,      5'h1C, 2'b00, 16'h0000, 1'b1, -1, -1, 16'hA5C3, 0, 1, 1, 0, 17, 16'h0000, 16'h001C});
    vecs.push_back(vec_t'{32, 2'b01, 2'b11, PHY,      5'h0A, 2'b10, 16'hBEEF, 1'b0, -1, -1, 16'h0000, 0, 0, 0, 1, 0,  16'h0000, 16'h0000});
    vecs.push_back(vec_t'{32, 2'b01, 2'b10, 5'd4,     5'h03, 2'b00, 16'h0000, 1'b1, -1, -1, 16'h1234, 0, 0, 0, 0, 0,  16'h0000, 16'h0000});
    vecs.push_back(vec_t'{32, 2'b01, 2'b10, PHY,      5'h07, 2'b00, 16'h0000, 1'b1, 20, -1, 16'hFFFF, 0, 1, 0, 1, 6,  16'h0000, 16'h0007});
    vecs.push_back(vec_t'{32, 2'b01, 2'b10, PHY,      5'h02, 2'b00, 16'h0000, 1'b1, -1, 23, 16'h5555, 0, 1, 0, 0, 10, 16'h0000, 16'h0002});
    vecs.push_back(vec_t'{32, 2'b01, 2'b01, PHY,      5'h11, 2'b10, 16'h0F0F, 1'b0, -1, -1, 16'h0000, 1, 0, 1, 0, 0,  16'h0F0F, 16'h0011});
`ifdef MDIO_C45_EN
    vecs.push_back(vec_t'{32, 2'b00, 2'b00, PHY,      5'h03, 2'b10, 16'hFFFF, 1'b0, -1, -1, 16'h0000, 0, 0, 1, 0, 0,  16'h0000, 16'hFFFF});
    vecs.push_back(vec_t'{32, 2'b00, 2'b10, PHY,      5'h03, 2'b00, 16'h0000, 1'b1, -1, -1, 16'hC0DE, 0, 1, 1, 0, 17, 16'h0000, 16'hFFFF});
    vecs.push_back(vec_t'{32, 2'b00, 2'b11, PHY,      5'h03, 2'b00, 16'h0000, 1'b1, -1, -1, 16'h0ACE, 0, 1, 1, 0, 17, 16'h0000, 16'h0000});
`else
    vecs.push_back(vec_t'{32, 2'b00, 2'b01, PHY,      5'h03, 2'b10, 16'h1234, 1'b0, -1, -1, 16'h0000, 0, 0, 0, 1, 0,  16'h0000, 16'h0000});
`endif

    foreach (vecs[i]) run_vec(i, vecs[i]);

`ifdef MDIO_C45_EN
    check("c45 final addr", 32'(ADDR), 32'h0000);
    check("c45 devad", 32'(DEV_ADDR), 32'd3);
`else
    check("c22 final addr", 32'(ADDR), 32'h0011);
    check("c22 devad", 32'(DEV_ADDR), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdio_phy_recep.md
# mdio_phy_recep

Parametrised PHY-side MDIO management-frame receiver, the successor of the current Clause 22 receiver. It decodes serial frames from the station management on MDC/MDIO and responds only to its own PHY address. Write frames are turned into a register-write strobe. Read frames fetch register data and are serialised back onto the bus. Optional Clause 45 support adds indirect addressing and post-increment reads.

## Interface
- PHY_ADDR, 5'd0: PHY address this instance responds to.
- PRE_LEN, 32: consecutive preamble 1s required before ST; legal range 1..32.
- MDC  in  1: management clock; all logic on its rising edge.
- rst  in  1: asynchronous, active-low reset.
- MDIO_OE  in  1: station is driving the line.
- MDIO_OUT  in  1: bit driven by the station.
- RD_DATA  in  16: register read data; must be valid on the MDC edge after RD_STB.
- MDIO_IN  out  1: bit driven back to the station.
- MDIO_IN_OE  out  1: receiver drive enable.
- RD_STB  out  1: one-cycle read request.
- WR_STB  out  1: one-cycle write strobe.
- MDIO_DONE  out  1: one-cycle end-of-frame pulse.
- ERR  out  1: one-cycle frame-error pulse.
- ADDR  out  16: register address. In C22 frames, [4:0] = REGAD and [15:5] = 0.
- DEV_ADDR  out  5: Clause 45 DEVAD. It is 0 for C22 frames.
- WR_DATA  out  16: write data, valid while WR_STB is high and held afterwards.

## Operation
- Sampling:
  - MDIO_OUT is sampled only when MDIO_OE = 1.
  - A sample taken with MDIO_OE = 0 during a station-driven phase aborts the frame with ERR.
- States:
  - IDLE counts consecutive 1s, saturating at PRE_LEN. A 0 clears the count.
  - When the count equals PRE_LEN and a 0 arrives, go to ST2.
  - ST2 takes the second ST bit: 1 = C22, 0 = C45 (see Configuration).
  - OP takes 2 bits, then PHYAD takes 5, then REGAD/DEVAD takes 5, then TA takes 2, then DATA takes 16, then return to IDLE.
- C22 opcodes: 01 = write, 10 = read. Any other opcode gives ERR and returns to IDLE.
- PHYAD mismatch: the frame is still tracked to its end to keep alignment. There are no strobes, no drive, no MDIO_DONE and no ERR.
- Write frames:
  - TA must be 10, otherwise ERR and return to IDLE.
  - Data is shifted in MSB first.
  - After D0 is sampled, WR_STB and MDIO_DONE pulse together. WR_DATA and ADDR are valid during that pulse.
- Read frames:
  - RD_STB pulses in the TA1 cycle.
  - RD_DATA is loaded into the output serializer at the end of TA1.
  - MDIO_IN_OE is high for TA2 and D15..D0, i.e. 17 cycles.
  - MDIO_IN is 0 during TA2, then D15..D0 MSB first.
  - MDIO_DONE pulses in the cycle after D0. MDIO_IN_OE is low by then.
  - MDIO_OE = 1 at any point from TA2 to D0 is contention: ERR, immediate release (MDIO_IN_OE = 0), return to IDLE.
- Back-to-back frames: the preamble count is cleared at the end of every frame, so each frame needs a full PRE_LEN preamble.
- Simultaneous events: ERR always takes precedence. MDIO_DONE, WR_STB and RD_STB are never asserted in the same cycle as ERR.

## Timing
- Reset values: MDIO_IN, MDIO_IN_OE, RD_STB, WR_STB, MDIO_DONE, ERR, ADDR, DEV_ADDR, WR_DATA are all 0. State = IDLE, preamble count = 0.
- Reset mid-frame: the above applies immediately (asynchronously). The bus is released in the same instant.
- Outputs are registered and change only after a rising MDC edge.
- Write latency: WR_STB is high in the cycle after the D0 sample edge.
- Read latency: 1 cycle from RD_STB to RD_DATA capture. D15 appears on MDIO_IN 2 cycles after RD_STB rises.
- Frame length after preamble: 32 cycles.

## Configuration
- Macro: MDIO_C45_EN.
- Without the macro:
  - ST = 00 produces ERR and a return to IDLE.
  - ADDR[15:5] and DEV_ADDR are constant 0.
- With the macro, ST = 00 frames are decoded. The field after PHYAD is DEVAD, which is latched to DEV_ADDR. TA = 10 is required for opcodes 00 and 01.
- C45 opcodes:
  - 00: load the 16 data bits into the internal address register, which drives ADDR. MDIO_DONE pulses; no WR_STB.
  - 01: write to ADDR.
  - 11: read from ADDR.
  - 10: read, then increment ADDR on the MDIO_DONE cycle. 0xFFFF wraps to 0x0000.

## Structure
- Package mdio_pkg: state encoding, ST_C22/ST_C45, the opcode constants, TA_WR = 2'b10, DATA_W = 16.
- Sub-module mdio_shift_out: 16-bit parallel-load, MSB-first serializer with load and shift enables. It drives MDIO_IN.

## Test plan
- Valid C22 write (PRE_LEN = 32): 32 ones, ST 01, OP 01, PHYAD = PHY_ADDR, REGAD 0x0A, TA 10, data 0xBEEF -> one WR_STB, WR_DATA = 0xBEEF, ADDR = 0x000A, MDIO_DONE in the same cycle.
- Valid C22 read of REGAD 0x03 with RD_DATA = 0x1234 -> RD_STB in TA1; MDIO_IN_OE high for 17 cycles; MDIO_IN = 0, then 0x1234 MSB first; then MDIO_DONE.
- C22 write to PHYAD = PHY_ADDR+1 -> no WR_STB, no MDIO_DONE, no ERR. A following valid frame is still accepted.
- Write with TA = 11, and separately a frame with only 31 preamble ones -> ERR pulse with no WR_STB, and no frame detected, respectively.
- rst low during D7 of a read -> MDIO_IN_OE = 0 immediately, all outputs 0. The next full frame decodes normally.
- MDIO_C45_EN: address 0xFFFF, read-increment, then read -> ADDR = 0xFFFF, then 0x0000; two RD_STB pulses. Without the macro, ST 00 -> ERR.
